// File: rtl/phase_sequencer_pkg.sv
// phase_sequencer_pkg: shared phase index constants and sequencer state type
package phase_sequencer_pkg;
  localparam int PH_DECODE = 0;
  localparam int PH_EXEC   = 1;
  localparam int PH_RDMEM  = 2;
  localparam int PH_FETCH  = 3;
  typedef enum logic {ST_RUN, ST_HALTED} state_e;
endpackage

// File: rtl/phase_next_sel.sv
// phase_next_sel: finds the first unskipped phase after cur in ring order
module phase_next_sel
  import phase_sequencer_pkg::*;
#(
  parameter int NUM_PHASES = 4
) (
  input  logic [$clog2(NUM_PHASES)-1:0] cur,
  input  logic [NUM_PHASES-1:0]         skip_mask,
  output logic [$clog2(NUM_PHASES)-1:0] nxt,
  output logic                          wrap
);
  localparam int IW = $clog2(NUM_PHASES);
  logic [IW-1:0] c;
  // Scan farthest-first so the nearest unskipped candidate is the last one written
  always_comb begin
    nxt = IW'(PH_DECODE);
    c = '0;
    for (int k = NUM_PHASES - 1; k >= 1; k--) begin
      c = IW'((int'(cur) + k) % NUM_PHASES);
      if (c == IW'(PH_DECODE) || !skip_mask[c]) nxt = c;
    end
  end
  assign wrap = nxt == IW'(PH_DECODE);
endmodule

// File: rtl/phase_sequencer.sv
// phase_sequencer: ring phase generator with stall, skip, boundary halt/resume and cycle counter
module phase_sequencer
  import phase_sequencer_pkg::*;
#(
  parameter int NUM_PHASES  = 4,
  parameter int RESET_PHASE = 2,
  parameter int CNT_W       = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stall,
  input  logic [NUM_PHASES-1:0]         skip_mask,
  input  logic                          halt_req,
  input  logic                          run,
  output logic [NUM_PHASES-1:0]         phase,
  output logic [$clog2(NUM_PHASES)-1:0] phase_idx,
  output logic                          last_phase,
  output logic                          halted,
  output logic [CNT_W-1:0]              cycle_cnt
);
  localparam int IW = $clog2(NUM_PHASES);
  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, nxt;
  logic [NUM_PHASES-1:0] phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic last_q, last_d, wrap;
  phase_next_sel #(.NUM_PHASES(NUM_PHASES)) u_next (
    .cur(idx_q), .skip_mask(skip_mask), .nxt(nxt), .wrap(wrap)
  );
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    if (state_q == ST_HALTED) begin
      if (run) begin
        state_d = ST_RUN;
        idx_d = IW'(PH_DECODE);
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (!stall) begin
      if (wrap && halt_req) begin
        state_d = ST_HALTED;
        idx_d = IW'(PH_DECODE);
      end else begin
        idx_d = nxt;
        cnt_d = wrap ? cnt_q + CNT_W'(1) : cnt_q;
      end
    end
    phase_d = (state_d == ST_RUN) ? NUM_PHASES'(1) << idx_d : '0;
    last_d = (state_d == ST_RUN) && (idx_d == IW'(NUM_PHASES - 1));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      idx_q <= IW'(RESET_PHASE);
      phase_q <= NUM_PHASES'(1) << RESET_PHASE;
      last_q <= RESET_PHASE == NUM_PHASES - 1;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      phase_q <= phase_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
    end
  end
  assign phase = phase_q;
  assign phase_idx = idx_q;
  assign last_phase = last_q;
  assign halted = state_q == ST_HALTED;
  assign cycle_cnt = cnt_q;
endmodule
